// File: rtl/vga_scan_driver_if.sv
// vga_scan_driver_if: pixel-source bus between the scan driver and GUI pixel sources
//   row/col   : current scan address (v_count/h_count), driven by the scan side
//   enable    : one-clock pixel tick, driven by the scan side
//   visible   : address lies inside the visible area, driven by the scan side
//   pixel_rgb : combinational colour answer from the pixel sources
interface vga_scan_driver_if;
   logic [9:0] row;
   logic [9:0] col;
   logic       enable;
   logic       visible;
   logic [2:0] pixel_rgb;
   modport master (output row, col, enable, visible, input pixel_rgb);
   modport slave (input row, col, enable, visible, output pixel_rgb);
endinterface

// File: rtl/vga_scan_driver.sv
// vga_scan_driver: VGA timing generator that scans pixel sources and registers colour/sync
//   clock      : system clock, rising edge
//   reset      : asynchronous active-low reset
//   pix        : pixel-source bus (master side)
//   frame_tick : one-clock pulse per frame after the last visible pixel
//   vga_rgb    : registered colour {R,G,B}, blanked outside the visible area
//   hsync      : horizontal sync, active low, delayed one pixel with vga_rgb
//   vsync      : vertical sync, active low, delayed one pixel with vga_rgb
module vga_scan_driver #(
   parameter int H_VISIBLE     = 640,
   parameter int H_FRONT       = 16,
   parameter int H_SYNC        = 96,
   parameter int H_BACK        = 48,
   parameter int V_VISIBLE     = 480,
   parameter int V_FRONT       = 10,
   parameter int V_SYNC        = 2,
   parameter int V_BACK        = 33,
   parameter int CLOCK_DIVIDER = 2
) (
   input  logic               clock,
   input  logic               reset,
   vga_scan_driver_if.master  pix,
   output logic               frame_tick,
   output logic [2:0]         vga_rgb,
   output logic               hsync,
   output logic               vsync
);
   localparam int DW = CLOCK_DIVIDER > 1 ? $clog2(CLOCK_DIVIDER) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLOCK_DIVIDER - 1);
   localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [DW-1:0] div_count;
   logic [9:0]    h_count;
   logic [9:0]    v_count;
   logic          tick;
   logic          div_last;
   logic          h_last;
   logic          v_last;
   logic          visible;

   assign div_last    = div_count == DIV_LAST;
   assign h_last      = h_count == H_LAST;
   assign v_last      = v_count == V_LAST;
   assign visible     = (h_count < H_VIS) && (v_count < V_VIS);
   assign pix.row     = v_count;
   assign pix.col     = h_count;
   assign pix.enable  = tick;
   assign pix.visible = visible;

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         div_count  <= '0;
         h_count    <= '0;
         v_count    <= '0;
         tick       <= 1'b0;
         frame_tick <= 1'b0;
         vga_rgb    <= '0;
         hsync      <= 1'b1;
         vsync      <= 1'b1;
      end else begin
         div_count  <= div_last ? '0 : div_count + 1'b1;
         tick       <= div_last;
         frame_tick <= tick && h_last && v_count == V_VIS_LAST;
         // Colour and sync are sampled from the current address, so they
         // appear one pixel later, all mutually aligned.
         if (tick) begin
            h_count <= h_last ? '0 : h_count + 10'd1;
            if (h_last)
               v_count <= v_last ? '0 : v_count + 10'd1;
            vga_rgb <= visible ? pix.pixel_rgb : 3'b000;
            hsync   <= !(h_count >= HS_START && h_count <= HS_END);
            vsync   <= !(v_count >= VS_START && v_count <= VS_END);
         end
      end
endmodule

// File: tb/tb_vga_scan_driver.sv
// tb_vga_scan_driver: randomized-colour scan check of vga_scan_driver against a pixel-count model
module tb_vga_scan_driver;
   localparam int HV = 8, HF = 2, HS = 3, HB = 2;
   localparam int VV = 6, VF = 2, VS = 2, VB = 2;
   localparam int DIV = 2;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FRAME = HT * VT * DIV;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       frame_tick;
   logic       hsync;
   logic       vsync;
   logic [2:0] vga_rgb;
   logic [2:0] lut [HT*VT];
   int errors = 0;
   int checks = 0;
   int e = 0;

   always #5 clock = ~clock;

   vga_scan_driver_if pix();

   always_comb pix.pixel_rgb = lut[(int'(pix.row) * HT + int'(pix.col)) % (HT * VT)];

   vga_scan_driver #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .CLOCK_DIVIDER(DIV)
   ) dut (
      .clock(clock), .reset(reset), .pix(pix), .frame_tick(frame_tick),
      .vga_rgb(vga_rgb), .hsync(hsync), .vsync(vsync)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
      end
   endtask

   // Enable is high after edge n when n is a positive multiple of DIV; pixels
   // completed after edge n are the enables seen before edges 1..n.
   function automatic bit en_after(input int n);
      return n >= DIV && n % DIV == 0;
   endfunction

   function automatic int pixels(input int n);
      return n > 0 ? (n - 1) / DIV : 0;
   endfunction

   task automatic check_cycle();
      int k, c, r, pc, pr;
      logic [2:0] rgb;
      logic hs, vs, ft;
      k = pixels(e);
      c = k % HT;
      r = (k / HT) % VT;
      chk("row", 32'(pix.row), 32'(r));
      chk("col", 32'(pix.col), 32'(c));
      chk("enable", 32'(pix.enable), 32'(en_after(e)));
      chk("visible", 32'(pix.visible), 32'(c < HV && r < VV));
      rgb = 3'b000; hs = 1'b1; vs = 1'b1; ft = 1'b0;
      if (k >= 1) begin
         pc = (k - 1) % HT;
         pr = ((k - 1) / HT) % VT;
         rgb = (pc < HV && pr < VV) ? lut[pr * HT + pc] : 3'b000;
         hs = !(pc >= HV + HF && pc < HV + HF + HS);
         vs = !(pr >= VV + VF && pr < VV + VF + VS);
         ft = en_after(e - 1) && pc == HT - 1 && pr == VV - 1;
      end
      chk("vga_rgb", 32'(vga_rgb), 32'(rgb));
      chk("hsync", 32'(hsync), 32'(hs));
      chk("vsync", 32'(vsync), 32'(vs));
      chk("frame_tick", 32'(frame_tick), 32'(ft));
   endtask

   task automatic step();
      @(posedge clock);
      e++;
      @(negedge clock);
      check_cycle();
   endtask

   initial begin
      for (int mode = 0; mode < 3; mode++) begin
         int t1, t2, hlow, vlow;
         for (int i = 0; i < HT * VT; i++)
            lut[i] = mode == 0 ? 3'($urandom) : mode == 1 ? 3'b101 : 3'(i % HT);
         reset = 1'b0;
         e = 0;
         repeat (3) @(negedge clock);
         check_cycle();
         reset = 1'b1;
         t1 = -1; t2 = -1; hlow = 0; vlow = 0;
         for (int n = 0; n < 3 * FRAME && t2 < 0; n++) begin
            step();
            if (t1 >= 0) begin
               hlow += hsync ? 0 : 1;
               vlow += vsync ? 0 : 1;
            end
            if (frame_tick) begin
               if (t1 < 0) t1 = e;
               else t2 = e;
            end
         end
         chk("second_frame_tick_seen", 32'(t2 >= 0), 32'd1);
         chk("frame_period", 32'(t2 - t1), 32'(FRAME));
         chk("hsync_low_clocks", 32'(hlow), 32'(VT * HS * DIV));
         chk("vsync_low_clocks", 32'(vlow), 32'(VS * HT * DIV));
      end
      begin
         int n = 0;
         while (!(pix.row == 10'd3 && pix.col == 10'd5) && n < 2 * FRAME) begin
            step();
            n++;
         end
         chk("reached_3_5", 32'(n < 2 * FRAME), 32'd1);
         reset = 1'b0;
         #1;
         chk("arst_row", 32'(pix.row), 32'd0);
         chk("arst_col", 32'(pix.col), 32'd0);
         chk("arst_enable", 32'(pix.enable), 32'd0);
         chk("arst_rgb", 32'(vga_rgb), 32'd0);
         chk("arst_hsync", 32'(hsync), 32'd1);
         chk("arst_vsync", 32'(vsync), 32'd1);
         chk("arst_frame_tick", 32'(frame_tick), 32'd0);
         @(negedge clock);
         reset = 1'b1;
         e = 0;
         repeat (4 * HT) step();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
